// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter family.
// Data formats, frame length helper and counter width helper.
package i2s_pkg;

    localparam int FMT_I2S = 0;
    localparam int FMT_LJ  = 1;

    // BCK cycles in one stereo frame
    function automatic int frame_len(input int slot_bits);
        return 2 * slot_bits;
    endfunction

    // Counter width for a 0..n-1 counter, never below 1 bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// BCK divider: toggles bck every BCK_DIV clk and flags each edge.
// Ports: clk_i, rst_ni (async, active-low) -> bck_o, fall_stb_o, rise_stb_o.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic bck_o,
    output logic fall_stb_o,
    output logic rise_stb_o
);

    localparam int DW = cnt_w(BCK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          bck_q;
    logic          bck_d;
    logic          wrap;

    assign wrap = (div_q == DIV_LAST);

    always_comb begin
        div_d = wrap ? '0 : div_q + DW'(1);
        bck_d = wrap ? ~bck_q : bck_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end

    // Strobes are high in the clk before bck actually changes,
    // so registers updated on them move together with bck.
    assign fall_stb_o = wrap & bck_q;
    assign rise_stb_o = wrap & ~bck_q;
    assign bck_o      = bck_q;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S / left-justified transmitter with one-deep holding register.
// Ports: clk, resetn, left, right, valid -> ready, din, bck, lrck,
//        frame_tick, underrun.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32,
    parameter int BCK_DIV     = 4,
    parameter int FORMAT      = FMT_I2S
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [SAMPLE_BITS-1:0] left,
    input  logic [SAMPLE_BITS-1:0] right,
    input  logic                   valid,
    output logic                   ready,
    output logic                   din,
    output logic                   bck,
    output logic                   lrck,
    output logic                   frame_tick,
    output logic                   underrun
);

    localparam int FL = frame_len(SLOT_BITS);
    localparam int PW = cnt_w(FL);
    localparam logic [PW-1:0] POS_LAST = PW'(FL - 1);
    localparam logic [PW-1:0] SLOT     = PW'(SLOT_BITS);

    logic fall_stb;
    logic unused_rise_stb;

    i2s_clkgen #(
        .BCK_DIV(BCK_DIV)
    ) u_clkgen (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .bck_o     (bck),
        .fall_stb_o(fall_stb),
        .rise_stb_o(unused_rise_stb)
    );

    logic [PW-1:0]          pos_q, pos_d;
    logic [SAMPLE_BITS-1:0] frame_l_q, frame_l_d;
    logic [SAMPLE_BITS-1:0] frame_r_q, frame_r_d;
    logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
    logic [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
    logic                   ready_q, ready_d;
    logic                   din_q, din_d;
    logic                   lrck_q, lrck_d;
    logic                   tick_q, tick_d;
    logic                   urun_q, urun_d;

    logic [PW-1:0] pos_adv;
    logic [PW-1:0] pos_lead;
    logic          load;
    logic          accept;

    function automatic logic ch_of(input logic [PW-1:0] p);
        return p >= SLOT;
    endfunction

    // Bit sent at frame position p; shifting past the LSB yields the pad zeros.
    function automatic logic bit_at(input logic [PW-1:0]          p,
                                    input logic [SAMPLE_BITS-1:0] l,
                                    input logic [SAMPLE_BITS-1:0] r);
        logic [PW-1:0]          k;
        logic [SAMPLE_BITS-1:0] w;
        k = ch_of(p) ? p - SLOT : p;
        w = ch_of(p) ? r : l;
        w = w << k;
        return w[SAMPLE_BITS-1];
    endfunction

    always_comb begin
        pos_adv  = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
        pos_lead = (pos_adv == POS_LAST) ? '0 : pos_adv + PW'(1);
        load     = fall_stb & (pos_q == POS_LAST);
        accept   = valid & ready_q;
    end

    always_comb begin
        pos_d     = pos_q;
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        ready_d   = ready_q;
        din_d     = din_q;
        lrck_d    = lrck_q;
        tick_d    = load;
        // Load decision uses the pre-cycle holding state, so a pair
        // accepted on the load cycle waits for the next frame.
        urun_d    = load & ready_q;

        if (load && !ready_q) begin
            frame_l_d = hold_l_q;
            frame_r_d = hold_r_q;
            ready_d   = 1'b1;
        end

        if (accept) begin
            hold_l_d = left;
            hold_r_d = right;
            ready_d  = 1'b0;
        end

        if (fall_stb) begin
            pos_d = pos_adv;
            din_d = bit_at(pos_adv, frame_l_d, frame_r_d);
            // I2S leads the data by one BCK on the word clock
            lrck_d = (FORMAT == FMT_LJ) ? ch_of(pos_adv) : ch_of(pos_lead);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q     <= POS_LAST;
            frame_l_q <= '0;
            frame_r_q <= '0;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            ready_q   <= 1'b1;
            din_q     <= 1'b0;
            lrck_q    <= 1'b0;
            tick_q    <= 1'b0;
            urun_q    <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            frame_l_q <= frame_l_d;
            frame_r_q <= frame_r_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            ready_q   <= ready_d;
            din_q     <= din_d;
            lrck_q    <= lrck_d;
            tick_q    <= tick_d;
            urun_q    <= urun_d;
        end
    end

    assign ready      = ready_q;
    assign din        = din_q;
    assign lrck       = lrck_q;
    assign frame_tick = tick_q;
    assign underrun   = urun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: I2S 16/16/2 instance plus a
// left-justified 24/32/1 instance.
module tb_i2s_tx;

    localparam int N = 32;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [15:0] left, right;
    logic        valid;
    logic        ready, din, bck, lrck, frame_tick, underrun;

    logic [23:0] left2, right2;
    logic        valid2;
    logic        ready2, din2, bck2, lrck2, ft2, ur2;

    i2s_tx #(
        .SAMPLE_BITS(16), .SLOT_BITS(16), .BCK_DIV(2), .FORMAT(0)
    ) dut (
        .clk(clk), .resetn(resetn), .left(left), .right(right),
        .valid(valid), .ready(ready), .din(din), .bck(bck),
        .lrck(lrck), .frame_tick(frame_tick), .underrun(underrun)
    );

    i2s_tx #(
        .SAMPLE_BITS(24), .SLOT_BITS(32), .BCK_DIV(1), .FORMAT(1)
    ) dut_lj (
        .clk(clk), .resetn(resetn), .left(left2), .right(right2),
        .valid(valid2), .ready(ready2), .din(din2), .bck(bck2),
        .lrck(lrck2), .frame_tick(ft2), .underrun(ur2)
    );

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   lj_done = 0;

    logic [15:0] bl [4] = '{16'h1234, 16'h8001, 16'hFFFF, 16'h3C3C};
    logic [15:0] br [4] = '{16'hFEDC, 16'h7FFE, 16'h0000, 16'hC3C3};

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_tick(input string name);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!frame_tick && k < 300);
        if (!frame_tick) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no frame_tick within 300 clk", name);
        end
    endtask

    task automatic wait_acc(input string name, input int old);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (n_acc == old && k < 300);
        if (n_acc == old) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no accept within 300 clk", name);
        end
    endtask

    // Each accepted pair is expected in a later frame, in order
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resetn && valid && ready) begin
            sbq.push_back({left, right, 1'b0});
            n_acc <= n_acc + 1;
        end
    end

    // Monitor: capture din/lrck on each bck rise of a frame, then compare
    initial begin
        logic [N-1:0] dv, lv;
        logic [15:0]  gl, gr;
        logic         pb, pd, pl, ur_seen;
        exp_t         e;
        int           bc;
        bit           cap;
        cap = 0;
        bc = 0;
        ur_seen = 0;
        dv = '0;
        lv = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                cap = 0;
                sbq.delete();
            end else begin
                if (din !== pd || lrck !== pl)
                    chk("edge_align", {pb, bck}, 2'b10);
                if (frame_tick) begin
                    cap = 1;
                    bc = 0;
                    ur_seen = underrun;
                end
                if (cap && bck && !pb) begin
                    dv[bc] = din;
                    lv[bc] = lrck;
                    bc++;
                    if (bc == N) begin
                        cap = 0;
                        for (int p = 0; p < 16; p++) begin
                            gl[15-p] = dv[p];
                            gr[15-p] = dv[16+p];
                        end
                        if (sbq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_empty: got L=%h R=%h", gl, gr);
                        end else begin
                            e = sbq.pop_front();
                            chk("frame_left", gl, e.l);
                            chk("frame_right", gr, e.r);
                            chk("frame_urun", ur_seen, e.ur);
                            chk("frame_lrck", lv, 32'h7FFF8000);
                        end
                    end
                end
            end
            pb = bck;
            pd = din;
            pl = lrck;
        end
    end

    // Left-justified instance: one frame plus the next MSB
    initial begin
        logic [64:0] d2, l2;
        logic [23:0] g2l, g2r;
        logic [7:0]  padl, padr;
        logic        pb2;
        int          k, j;
        d2 = '0;
        l2 = '0;
        wait (resetn === 1'b1);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ft2 && k < 50);
        chk("lj_tick_seen", ft2, 1'b1);
        pb2 = bck2;
        j = 0;
        k = 0;
        while (j < 65 && k < 400) begin
            @(negedge clk);
            k++;
            if (bck2 && !pb2) begin
                d2[j] = din2;
                l2[j] = lrck2;
                j++;
            end
            pb2 = bck2;
        end
        chk("lj_bits_seen", j, 65);
        for (int p = 0; p < 24; p++) begin
            g2l[23-p] = d2[p];
            g2r[23-p] = d2[32+p];
        end
        for (int p = 0; p < 8; p++) begin
            padl[7-p] = d2[24+p];
            padr[7-p] = d2[56+p];
        end
        chk("lj_left", g2l, 24'h800001);
        chk("lj_left_pad", padl, 8'h00);
        chk("lj_right", g2r, 24'h7FFFFE);
        chk("lj_right_pad", padr, 8'h00);
        chk("lj_lrck", l2[63:0], 64'hFFFFFFFF00000000);
        chk("lj_msb_on_lrck_fall", {l2[63], l2[64], d2[64]}, 3'b101);
        lj_done = 1;
    end

    initial begin
        int cnt;
        int old;
        int t_acc [4];
        resetn = 1'b0;
        valid  = 1'b1;
        left   = 16'hA5F0;
        right  = 16'h0F0F;
        valid2 = 1'b1;
        left2  = 24'h800001;
        right2 = 24'h7FFFFE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bck", bck, 1'b0);
        chk("rst_lrck", lrck, 1'b0);
        chk("rst_din", din, 1'b0);
        chk("rst_tick", frame_tick, 1'b0);
        chk("rst_urun", underrun, 1'b0);
        chk("rst_ready", ready, 1'b1);

        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        cnt = 1;
        chk("ready_fall", ready, 1'b0);
        while (!frame_tick && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("first_load_clk", cnt, 4);
        chk("first_urun", underrun, 1'b0);
        chk("ready_rise", ready, 1'b1);

        sbq.push_back({16'hA5F0, 16'h0F0F, 1'b1});
        sbq.push_back({16'hA5F0, 16'h0F0F, 1'b1});
        for (int i = 0; i < 2; i++) begin
            wait_tick("urun_tick");
            chk("urun_pulse", underrun, 1'b1);
            chk("urun_ready", ready, 1'b1);
            @(posedge clk); #1;
            chk("urun_width", underrun, 1'b0);
        end

        old = n_acc;
        valid = 1'b1;
        left  = bl[0];
        right = br[0];
        for (int i = 0; i < 4; i++) begin
            wait_acc("bp_accept", old);
            old = n_acc;
            t_acc[i] = cyc;
            if (i >= 2)
                chk("accept_period", t_acc[i] - t_acc[i-1], 128);
            if (i < 3) begin
                left  = bl[i+1];
                right = br[i+1];
            end else begin
                valid = 1'b0;
            end
        end

        sbq.push_back({bl[3], br[3], 1'b1});
        wait_tick("sim_pre");
        repeat (127) @(posedge clk);
        #1;
        valid = 1'b1;
        left  = 16'h5A5A;
        right = 16'h0001;
        @(posedge clk); #1;
        valid = 1'b0;
        chk("sim_tick", frame_tick, 1'b1);
        chk("sim_urun", underrun, 1'b1);
        chk("sim_ready", ready, 1'b0);

        wait_tick("pre_rst");
        valid = 1'b1;
        left  = 16'hA5F0;
        right = 16'h0F0F;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_tick("rst_frame");
        valid = 1'b1;
        left  = 16'h1111;
        right = 16'h2222;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pos7_bck", bck, 1'b1);
        chk("pos7_din", din, 1'b1);
        chk("pos7_ready", ready, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mid_bck", bck, 1'b0);
        chk("mid_lrck", lrck, 1'b0);
        chk("mid_din", din, 1'b0);
        chk("mid_ready", ready, 1'b1);
        chk("mid_tick", frame_tick, 1'b0);
        chk("mid_urun", underrun, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        sbq.push_back({16'h0000, 16'h0000, 1'b1});
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!frame_tick && cnt < 20);
        chk("rst_load_clk", cnt, 4);
        chk("rst_load_urun", underrun, 1'b1);
        wait_tick("post_rst");
        chk("sb_drained", sbq.size(), 0);

        cnt = 0;
        while (!lj_done && cnt < 500) begin
            @(posedge clk);
            cnt++;
        end
        chk("lj_done", lj_done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parametrised stereo I2S/left-justified transmitter for PCM5102-class DACs. It generates BCK and LRCK from the system clock and shifts out MSB-first two's-complement or unsigned words, passed through unchanged. A valid/ready handshake feeds a one-deep stereo holding register, so producers in the 48 MHz fabric can supply samples asynchronously to the frame. Underruns are flagged. The block sits between the synth/mixer output and the DAC pins.

## Interface
- SAMPLE_BITS, 16: sample width per channel, 1..32.
- SLOT_BITS, 32: BCK cycles per channel slot, SAMPLE_BITS..64, at least 2.
- BCK_DIV, 4: clk cycles per BCK half-period, at least 1. BCK period is 2*BCK_DIV clk.
- FORMAT, 0: 0 = I2S (MSB one BCK after the LRCK edge); 1 = left-justified (MSB on the LRCK edge).
- clk  in  1  system clock (48 MHz)
- resetn  in  1  asynchronous, active-low reset
- left  in  SAMPLE_BITS  left sample
- right  in  SAMPLE_BITS  right sample
- valid  in  1  producer offers a left/right pair
- ready  out  1  holding register empty; the pair is accepted when valid && ready
- din  out  1  DAC serial data
- bck  out  1  DAC bit clock
- lrck  out  1  DAC word clock; 0 = left, 1 = right
- frame_tick  out  1  one-clk pulse when a new frame is loaded for output
- underrun  out  1  one-clk pulse when a frame starts with the holding register empty

## Operation
- **Divider:** counter 0..BCK_DIV-1 that wraps and toggles bck. Toggle 1→0 is the fall strobe; toggle 0→1 is the rise strobe.
- **Frame position:** pos runs 0..2*SLOT_BITS-1 and advances on each fall strobe, wrapping to 0.
  - ch = pos / SLOT_BITS; k = pos mod SLOT_BITS.
- **din:** updated on the fall strobe to frame_ch[SAMPLE_BITS-1-k] when k < SAMPLE_BITS, else 0 (zero pad after the LSB).
- **lrck:** updated on the fall strobe.
  - FORMAT 1: lrck = ch(pos).
  - FORMAT 0: lrck = ch((pos+1) mod 2*SLOT_BITS), i.e. it leads the data by one BCK.
- **Load:** on the fall strobe that moves pos to 0:
  - If the holding register is full, copy both channels into the frame register, clear full and pulse frame_tick.
  - If it is empty, keep the previous frame (repeat it), pulse underrun and also pulse frame_tick.
- **Handshake:** ready = !full. On valid && ready, capture left/right and set full. valid may drop at any time without effect.
- **Simultaneous accept and load:** the load uses the state from before that cycle. The pair accepted in that cycle waits for the next frame, and underrun fires for the current one.
- **Reset (asynchronous, resetn = 0):**
  - bck = 0, lrck = 0, din = 0, frame_tick = 0, underrun = 0, ready = 1.
  - Divider = 0, pos = 2*SLOT_BITS-1, frame and holding registers = 0, full = 0.
  - The first fall strobe after reset therefore performs a load.
- Reset asserted mid-frame aborts the frame immediately; there is no partial-word completion.

## Timing
- All outputs are registered; din and lrck change only with bck falling, so the DAC samples stable data on bck rising.
- First bck rise occurs BCK_DIV clk after resetn deasserts. First fall strobe (the first load) occurs at 2*BCK_DIV clk.
- Frame period: 2*SLOT_BITS*2*BCK_DIV clk. Defaults give 512 clk, which is 93.75 kHz at 48 MHz.
- ready falls the clk after acceptance and rises the clk after the load that empties the holding register.
- Worst-case latency from acceptance to the MSB on din is one frame period plus 1 clk.

## Structure
- Shared package i2s_pkg: FMT_I2S = 0, FMT_LJ = 1, and a function for the frame length (2*SLOT_BITS).
- One sub-module, i2s_clkgen: BCK divider producing the bck, fall-strobe and rise-strobe outputs. It is reusable by a future i2s_rx.

## Test plan
- **I2S default frame:** SAMPLE_BITS=16, SLOT_BITS=16, BCK_DIV=2, FORMAT=0; valid held high from reset with left=16'hA5F0, right=16'h0F0F → bck period 4 clk; lrck falls, and on the next bck fall din starts 1,0,1,0,0,1,0,1,…; right slot shows 0000111100001111.
- **Left-justified padding:** FORMAT=1, SAMPLE_BITS=24, SLOT_BITS=32, left=24'h800001 → MSB=1 coincident with the lrck fall, bits 1..22 = 0, bit 23 = 1, then 8 zero pad bits.
- **Underrun:** after one pair, hold valid low → underrun pulses once per frame; din repeats the same pattern each frame; ready stays 1.
- **Backpressure:** valid held high with pair values incrementing each accept → exactly one accept per frame period (128 clk at defaults); each pair is output once and in order; no underrun.
- **Simultaneous accept/load:** assert valid exactly on the load cycle with the holding register empty → underrun pulses that cycle; the pair appears at the following frame.
- **Reset mid-frame:** pull resetn low at pos=7 → bck, lrck, din = 0 and ready = 1 within the same clk; after release, the first load occurs 2*BCK_DIV clk later.
